axi_read_arbiter: RTL and testbench

//   Shares one AXI4 read channel (AR + R) between two read masters: master 0
//   is the instruction cache refill port and master 1 is the data cache or

---
 rtl/axi_read_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-master AXI4 read channel arbiter, one outstanding burst
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0: instruction cache refill
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [ID_WIDTH-1:0]   m0_rid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // master 1: data cache / uncached loads
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [ID_WIDTH-1:0]   m1_rid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // shared downstream read channel
  output logic [ID_WIDTH-1:0]   s_arid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   winner;
  logic   win_en;
  logic   burst_done;

  // Pick the next owner: a lone requester wins; a tie goes to the master not
  // served last (round-robin) or always to master 0 (fixed priority).
  always_comb begin
    if (m0_arvalid && m1_arvalid) begin
      winner = (RR_EN != 1'b0) ? ~last : 1'b0;
    end else begin
      winner = m1_arvalid;
    end
  end

  // State, owner and last-served registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (win_en) begin
        grant <= winner;
      end
      if (burst_done) begin
        last <= grant;
      end
    end
  end

  // Next state and the combinational AR/R steering toward the current owner.
  always_comb begin
    state_nxt  = state;
    win_en     = 1'b0;
    burst_done = 1'b0;
    busy       = (state != IDLE);
    s_arid     = '0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rid     = '0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rid     = '0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          win_en    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (grant) begin
          s_arid     = m1_arid;
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          s_arid     = m0_arid;
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end
        // A master that withdraws arvalid simply keeps us waiting here.
        if ((grant ? m1_arvalid : m0_arvalid) && s_arready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (grant) begin
          m1_rid    = s_rid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rid    = s_rid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rlast && (grant ? m1_rready : m0_rready)) begin
          burst_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - directed self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  m0_arid = '0, m1_arid = '0, s_rid = '0;
  logic [31:0] m0_araddr = '0, m1_araddr = '0, s_rdata = '0;
  logic [7:0]  m0_arlen = '0, m1_arlen = '0;
  logic [2:0]  m0_arsize = '0, m1_arsize = '0;
  logic [1:0]  m0_arburst = '0, m1_arburst = '0, s_rresp = '0;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0, m0_rready = 1'b1, m1_rready = 1'b1;
  logic        s_arready = 1'b0, s_rlast = 1'b0, s_rvalid = 1'b0;

  // outputs of the round-robin instance
  logic        m0_arready, m1_arready, m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic [3:0]  m0_rid, m1_rid, s_arid;
  logic [31:0] m0_rdata, m1_rdata, s_araddr;
  logic [1:0]  m0_rresp, m1_rresp, s_arburst;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic        s_arvalid, s_rready, busy, grant;

  // outputs of the fixed-priority instance
  logic        f_m0_arready, f_m1_arready, f_m0_rlast, f_m1_rlast, f_m0_rvalid, f_m1_rvalid;
  logic [3:0]  f_m0_rid, f_m1_rid, f_s_arid;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_araddr;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_s_arburst;
  logic [7:0]  f_s_arlen;
  logic [2:0]  f_s_arsize;
  logic        f_s_arvalid, f_s_rready, f_busy, f_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .busy(busy), .grant(grant)
  );

  axi_read_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
    .m0_rid(f_m0_rid), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rlast(f_m0_rlast),
    .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
    .m1_rid(f_m1_rid), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rlast(f_m1_rlast),
    .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
    .s_arid(f_s_arid), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize),
    .s_arburst(f_s_arburst), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(f_s_rready), .busy(f_busy), .grant(f_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Synchronous reset for two edges; checks the post-reset output state.
  task automatic do_reset();
    rst = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_outs", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    rst = 1'b1;
  endtask

  // Called in ADDR: completes AR handshake then an nbeats burst to master m.
  task automatic serve(input int m, input int nbeats, input bit drop);
    #1;
    chk("srv_grant", grant, m[0]);
    chk("srv_busy", busy, 1);
    chk("srv_arvalid", s_arvalid, 1);
    s_arready = 1'b1;
    #1;
    chk("srv_arready_own", (m != 0) ? m1_arready : m0_arready, 1);
    chk("srv_arready_other", (m != 0) ? m0_arready : m1_arready, 0);
    cyc();
    s_arready = 1'b0;
    if (drop) begin
      if (m != 0) m1_arvalid = 1'b0;
      else m0_arvalid = 1'b0;
    end
    for (int i = 0; i < nbeats; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = 32'hD000_0000 + 32'(m * 256 + i);
      s_rlast  = (i == nbeats - 1);
      #1;
      chk("beat_rvalid_own", (m != 0) ? m1_rvalid : m0_rvalid, 1);
      chk("beat_rdata_own", (m != 0) ? m1_rdata : m0_rdata, 32'hD000_0000 + 32'(m * 256 + i));
      chk("beat_rvalid_other", (m != 0) ? m0_rvalid : m1_rvalid, 0);
      chk("beat_rdata_other", (m != 0) ? m0_rdata : m1_rdata, 0);
      cyc();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    chk("srv_idle", busy, 0);
  endtask

  initial begin
    int beat;
    int c;
    bit v;
    bit r;

    // 1: lone m0 request, 16-beat burst
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h1FC0_0000; m0_arlen = 8'd15; m0_arid = 4'h5;
    #1;
    chk("t1_idle_arvalid", s_arvalid, 0);
    chk("t1_idle_arready", m0_arready, 0);
    cyc();
    chk("t1_araddr", s_araddr, 32'h1FC0_0000);
    chk("t1_arlen", s_arlen, 15);
    chk("t1_arid", s_arid, 4'h5);
    serve(0, 16, 1'b1);

    // 2: tie with round-robin, both held valid -> strict alternation
    do_reset();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_araddr = 32'h0000_2000;
    #1;
    chk("t2_idle_arvalid", s_arvalid, 0);
    cyc(); serve(0, 1, 1'b0);
    cyc(); serve(1, 1, 1'b0);
    cyc(); serve(0, 1, 1'b0);
    cyc(); serve(1, 1, 1'b0);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // 3: fixed priority keeps granting m0 while both stay valid
    do_reset();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    for (int rnd = 0; rnd < 3; rnd++) begin
      cyc();
      chk("t3_fp_grant", f_grant, 0);
      chk("t3_rr_grant", grant, rnd % 2);
      s_arready = 1'b1;
      cyc();
      s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
      #1;
      chk("t3_fp_m0_rvalid", f_m0_rvalid, 1);
      chk("t3_fp_m1_rvalid", f_m1_rvalid, 0);
      cyc();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      chk("t3_fp_idle", f_busy, 0);
    end
    m0_arvalid = 1'b0;
    cyc();
    chk("t3_fp_m1_grant", f_grant, 1);
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    chk("t3_fp_m1_rvalid", f_m1_rvalid, 1);
    cyc();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("t3_fp_done", f_busy, 0);

    // 4: AR stall, gapped R and toggling rready
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd3;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall_arvalid", s_arvalid, 1);
      chk("t4_stall_araddr", s_araddr, 32'h8000_0040);
      chk("t4_stall_arready", m0_arready, 0);
      cyc();
    end
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0; m0_arvalid = 1'b0;
    beat = 0;
    c = 0;
    while (beat < 4 && c < 40) begin
      v = ((c % 3) != 1);
      r = ((c % 2) == 0);
      s_rvalid = v; m0_rready = r;
      s_rdata = 32'h100 + 32'(beat); s_rlast = (beat == 3);
      #1;
      chk("t4_rready_mirror", s_rready, r);
      chk("t4_rvalid_pass", m0_rvalid, v);
      if (v) chk("t4_rdata", m0_rdata, 32'h100 + 32'(beat));
      if (v && r) beat++;
      cyc();
      c++;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b1;
    #1;
    chk("t4_beats", beat, 4);
    chk("t4_idle", busy, 0);

    // 5: reset during beat 3 of an m1 arlen=7 burst, then a fresh m1 request
    do_reset();
    m1_arvalid = 1'b1; m1_arlen = 8'd7;
    cyc();
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0; m1_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'(i);
      cyc();
    end
    chk("t5_pre_grant", grant, 1);
    rst = 1'b0;
    cyc();
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant, 0);
    chk("t5_outs", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    rst = 1'b1; s_rvalid = 1'b0;
    m1_arvalid = 1'b1;
    cyc();
    serve(1, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
